mdu_e: RTL

- Execute-stage multi-cycle multiply/divide unit with architectural HI/LO registers.
- Runs beside the single-cycle ALU and covers the opposite timing case: iterative, stalling ops with a busy handshake to the hazard unit.
- Takes SrcA/SrcB from the same E-stage forwarding muxes as the ALU.
- Supplies hiOut/loOut to the MFHI/MFLO path.

---
 rtl/mdu_e_pkg.sv | 27 ++
 rtl/mdu_e_md_sign_fix.sv | 51 +++++
 rtl/mdu_e.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mdu_e_pkg.sv
// Shared MDU definitions: opcode width, MD_* opcodes, FSM state encodings.
package mdu_e_pkg;

   localparam int MD_OP_LENGTH = 3;

   localparam logic [MD_OP_LENGTH-1:0] MD_MULT  = 3'd0;
   localparam logic [MD_OP_LENGTH-1:0] MD_MULTU = 3'd1;
   localparam logic [MD_OP_LENGTH-1:0] MD_DIV   = 3'd2;
   localparam logic [MD_OP_LENGTH-1:0] MD_DIVU  = 3'd3;
   localparam logic [MD_OP_LENGTH-1:0] MD_MTHI  = 3'd4;
   localparam logic [MD_OP_LENGTH-1:0] MD_MTLO  = 3'd5;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CALC   = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   // True for the iterative ops (MULT, MULTU, DIV, DIVU).
   function automatic logic is_muldiv(input logic [MD_OP_LENGTH-1:0] op);
      return (op <= MD_DIVU);
   endfunction

   // True for the signed variants (MULT, DIV).
   function automatic logic is_signed_op(input logic [MD_OP_LENGTH-1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/mdu_e_md_sign_fix.sv
// Combinational sign handling around the unsigned iterative core:
// operand magnitudes and result-sign flags before, conditional negation after.
module md_sign_fix #(
   parameter int DATA_WIDTH = 32
) (
   // pre-op side
   input  logic                    op_signed_i,
   input  logic [DATA_WIDTH-1:0]   a_i,
   input  logic [DATA_WIDTH-1:0]   b_i,
   output logic [DATA_WIDTH-1:0]   mag_a_o,
   output logic [DATA_WIDTH-1:0]   mag_b_o,
   output logic                    neg_q_o,
   output logic                    neg_r_o,
   // post-op side
   input  logic                    is_div_i,
   input  logic                    neg_q_i,
   input  logic                    neg_r_i,
   input  logic [2*DATA_WIDTH-1:0] acc_i,
   output logic [DATA_WIDTH-1:0]   hi_o,
   output logic [DATA_WIDTH-1:0]   lo_o
);

   logic                    sa, sb;
   logic [DATA_WIDTH-1:0]   quo, rem;
   logic [2*DATA_WIDTH-1:0] prod;

   // Magnitudes (0x80000000 maps to itself, read as unsigned) and sign flags.
   always_comb begin
      sa      = op_signed_i & a_i[DATA_WIDTH-1];
      sb      = op_signed_i & b_i[DATA_WIDTH-1];
      mag_a_o = sa ? (~a_i + 1'b1) : a_i;
      mag_b_o = sb ? (~b_i + 1'b1) : b_i;
      neg_q_o = sa ^ sb;
      neg_r_o = sa;
   end

   // Product: full-width negate; divide: independent quotient/remainder negates.
   always_comb begin
      quo  = acc_i[DATA_WIDTH-1:0];
      rem  = acc_i[2*DATA_WIDTH-1:DATA_WIDTH];
      prod = neg_q_i ? (~acc_i + 1'b1) : acc_i;
      if (is_div_i) begin
         lo_o = neg_q_i ? (~quo + 1'b1) : quo;
         hi_o = neg_r_i ? (~rem + 1'b1) : rem;
      end else begin
         lo_o = prod[DATA_WIDTH-1:0];
         hi_o = prod[2*DATA_WIDTH-1:DATA_WIDTH];
      end
   end

endmodule

// File: rtl/mdu_e.sv
// E-stage iterative multiply/divide unit with architectural HI/LO registers.
module mdu_e
   import mdu_e_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    startE,
   input  logic [MD_OP_LENGTH-1:0] mdOpE,
   input  logic [DATA_WIDTH-1:0]   SrcA,
   input  logic [DATA_WIDTH-1:0]   SrcB,
   input  logic                    flushE,
   output logic                    busyE,
   output logic                    doneE,
   output logic [DATA_WIDTH-1:0]   hiOut,
   output logic [DATA_WIDTH-1:0]   loOut
);

   logic [1:0]              state_q, state_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0]   opb_q, opb_d;      // multiplicand or divisor magnitude
   logic [DATA_WIDTH-1:0]   srca_q, srca_d;    // raw dividend for divide-by-zero
   logic [DATA_WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic                    isdiv_q, isdiv_d, negq_q, negq_d, negr_q, negr_d;
   logic                    dz_q, dz_d;

   logic [DATA_WIDTH-1:0]   mag_a, mag_b, fix_hi, fix_lo;
   logic                    pre_negq, pre_negr, start_md;
   logic [DATA_WIDTH:0]     mul_sum, div_top, div_diff;
   logic                    div_ge;
   logic [2*DATA_WIDTH-1:0] mul_next, div_next;

   md_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_sign_fix (
      .op_signed_i (is_signed_op(mdOpE)),
      .a_i         (SrcA),
      .b_i         (SrcB),
      .mag_a_o     (mag_a),
      .mag_b_o     (mag_b),
      .neg_q_o     (pre_negq),
      .neg_r_o     (pre_negr),
      .is_div_i    (isdiv_q),
      .neg_q_i     (negq_q),
      .neg_r_i     (negr_q),
      .acc_i       (acc_q),
      .hi_o        (fix_hi),
      .lo_o        (fix_lo)
   );

   assign start_md = startE & is_muldiv(mdOpE) & ~flushE;
   assign busyE    = (state_q != ST_IDLE) | start_md;
   assign doneE    = (state_q == ST_FINISH) & ~flushE;
   assign hiOut    = hi_q;
   assign loOut    = lo_q;

   // One iteration of shift-add multiply and restoring divide on the accumulator.
   // Divide keeps {remainder, quotient} in acc; the 33-bit top window holds the
   // bit shifted out of the remainder so a full-range divisor still compares right.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} +
                 (acc_q[0] ? {1'b0, opb_q} : {(DATA_WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc_q[DATA_WIDTH-1:1]};
      div_top  = acc_q[2*DATA_WIDTH-1:DATA_WIDTH-1];
      div_diff = div_top - {1'b0, opb_q};
      div_ge   = (div_top >= {1'b0, opb_q});
      div_next = {(div_ge ? div_diff[DATA_WIDTH-1:0] : div_top[DATA_WIDTH-1:0]),
                  acc_q[DATA_WIDTH-2:0], div_ge};
   end

   // FSM next-state, operand latch, iteration and HI/LO write logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      srca_d  = srca_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      isdiv_d = isdiv_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      case (state_q)
         ST_IDLE: begin
            if (startE) begin
               if (mdOpE == MD_MTHI) begin
                  hi_d = SrcA;
               end else if (mdOpE == MD_MTLO) begin
                  lo_d = SrcA;
               end else if (is_muldiv(mdOpE)) begin
                  state_d = ST_CALC;
                  cnt_d   = '0;
                  isdiv_d = mdOpE[1];
                  acc_d   = {{DATA_WIDTH{1'b0}}, (mdOpE[1] ? mag_a : mag_b)};
                  opb_d   = mdOpE[1] ? mag_b : mag_a;
                  srca_d  = SrcA;
                  negq_d  = pre_negq;
                  negr_d  = pre_negr;
                  dz_d    = (SrcB == '0);
               end
            end
         end
         ST_CALC: begin
            acc_d = isdiv_q ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) state_d = ST_FINISH;
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
            if (isdiv_q && dz_q) begin
               hi_d = srca_q;
               lo_d = '1;
            end else begin
               hi_d = fix_hi;
               lo_d = fix_lo;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Flush overrides everything above: abandon the op and keep HI/LO.
      if (flushE) begin
         state_d = ST_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         srca_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         isdiv_q <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         srca_q  <= srca_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         isdiv_q <= isdiv_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
      end
   end

endmodule
